// File: rtl/dcm_reset_ctrl_if.sv
// Signal bundle between the DCM reset/lock supervisor and the DCM plus its reset consumers.
// The master side is the supervisor; the slave side is the DCM and the downstream logic.
interface dcm_reset_ctrl_if #(
  parameter int RETRY_W = 3
);
  logic               dcm_locked;
  logic               dcm_rst;
  logic               sys_ready;
  logic               lock_lost;
  logic               fault;
  logic [RETRY_W-1:0] retry_cnt;

  modport master (
    input  dcm_locked,
    output dcm_rst, sys_ready, lock_lost, fault, retry_cnt
  );

  modport slave (
    output dcm_locked,
    input  dcm_rst, sys_ready, lock_lost, fault, retry_cnt
  );
endinterface

// File: rtl/dcm_reset_ctrl.sv
// DCM reset and lock supervisor: pulses the DCM reset, waits for lock with retries,
// qualifies lock over a stable window before sys_ready, and falls back on lock loss.
module dcm_reset_ctrl #(
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7,
  parameter int CNT_W         = 16,
  parameter int RETRY_W       = 3
) (
  input logic               clk,
  input logic               rst_n,
  dcm_reset_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_RESET_PULSE = 3'd0,
    S_WAIT_LOCK   = 3'd1,
    S_STABLE      = 3'd2,
    S_RUN         = 3'd3,
    S_FAULT       = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               sync1_q, sync2_q;
  logic               dcm_rst_q, sys_ready_q, lock_lost_q, fault_q;
  logic               lock_lost_d;
  logic               locked_s;

  // dcm_locked comes from the DCM's own clock domain; only sync2_q may be used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.dcm_locked;
      sync2_q <= sync1_q;
    end
  end

  assign locked_s = sync2_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;
    unique case (state_q)
      S_RESET_PULSE: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = '0;
          if (retry_q == RETRY_LAST) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_RESET_PULSE;
            retry_d = retry_q + RETRY_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_d     = S_RESET_PULSE;
          cnt_d       = '0;
          retry_d     = '0;
          lock_lost_d = 1'b1;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_RESET_PULSE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET_PULSE;
      cnt_q       <= '0;
      retry_q     <= '0;
      dcm_rst_q   <= 1'b1;
      sys_ready_q <= 1'b0;
      lock_lost_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      dcm_rst_q   <= (state_d == S_RESET_PULSE);
      sys_ready_q <= (state_d == S_RUN);
      lock_lost_q <= lock_lost_d;
      fault_q     <= (state_d == S_FAULT);
    end
  end

  assign bus.dcm_rst   = dcm_rst_q;
  assign bus.sys_ready = sys_ready_q;
  assign bus.lock_lost = lock_lost_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_dcm_reset_ctrl.sv
// Self-checking bench for dcm_reset_ctrl: hand-computed vector table, directed corner
// sequences, and randomized lock patterns compared against a timestamp-based reference model.
module tb_dcm_reset_ctrl;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;
  localparam int CNT_W         = 16;
  localparam int RETRY_W       = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  dcm_reset_ctrl_if #(.RETRY_W(RETRY_W)) bus ();

  dcm_reset_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES  (MAX_RETRIES),
    .CNT_W        (CNT_W),
    .RETRY_W      (RETRY_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Output snapshot packing: {dcm_rst, sys_ready, lock_lost, fault, retry_cnt[1:0]}
  function automatic logic [5:0] outs();
    return {bus.dcm_rst, bus.sys_ready, bus.lock_lost, bus.fault, bus.retry_cnt};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (rst,ready,lost,fault,retry)", name, act, exp);
    end
  endtask

  // Reference model: phases with entry timestamps; synchronizer as a two-sample delay line.
  typedef enum {M_PULSE, M_WAIT, M_STAB, M_RUN, M_FAULT} mphase_e;
  mphase_e ph;
  int      cyc, start, retries;
  bit      lost;
  bit      dly[$];

  function automatic void model_reset();
    ph      = M_PULSE;
    cyc     = 0;
    start   = -1;
    retries = 0;
    lost    = 1'b0;
    dly     = '{1'b0, 1'b0};
  endfunction

  function automatic void enter(input mphase_e p);
    ph    = p;
    start = cyc;
  endfunction

  function automatic void model_edge(input bit lk);
    bit ls;
    int el;
    ls = dly.pop_front();
    dly.push_back(lk);
    el   = cyc - start - 1;
    lost = 1'b0;
    case (ph)
      M_PULSE: if (el == RST_CYCLES - 1) enter(M_WAIT);
      M_WAIT: begin
        if (ls) enter(M_STAB);
        else if (el == LOCK_TIMEOUT - 1) begin
          if (retries == MAX_RETRIES) enter(M_FAULT);
          else begin
            retries++;
            enter(M_PULSE);
          end
        end
      end
      M_STAB: begin
        if (!ls) enter(M_WAIT);
        else if (el == STABLE_CYCLES - 1) enter(M_RUN);
      end
      M_RUN: if (!ls) begin
        lost    = 1'b1;
        retries = 0;
        enter(M_PULSE);
      end
      default: ;
    endcase
    cyc++;
  endfunction

  function automatic logic [5:0] model_outs();
    return {ph == M_PULSE, ph == M_RUN, lost, ph == M_FAULT, 2'(retries)};
  endfunction

  task automatic step(input logic lk);
    bus.dcm_locked = lk;
    @(posedge clk);
    model_edge(lk);
    @(negedge clk);
    check("model", outs(), model_outs());
  endtask

  task automatic steps(input int n, input logic lk);
    for (int i = 0; i < n; i++) step(lk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("async_reset", outs(), 6'b100000);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    int         n;
    logic       lk;
    logic [5:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{3, 1'b0, 6'b100000, "pulse_hold"};
    vecs[1]  = '{1, 1'b0, 6'b000000, "pulse_end_4"};
    vecs[2]  = '{9, 1'b0, 6'b000000, "wait_lock"};
    vecs[3]  = '{1, 1'b1, 6'b000000, "first_hi"};
    vecs[4]  = '{9, 1'b1, 6'b000000, "qualifying"};
    vecs[5]  = '{1, 1'b1, 6'b010000, "ready_edge11"};
    vecs[6]  = '{5, 1'b1, 6'b010000, "run_hold"};
    vecs[7]  = '{2, 1'b0, 6'b010000, "loss_sync"};
    vecs[8]  = '{1, 1'b0, 6'b101000, "loss_edge3"};
    vecs[9]  = '{1, 1'b0, 6'b100000, "lost_one_cycle"};
    vecs[10] = '{2, 1'b1, 6'b100000, "repulse"};
    vecs[11] = '{1, 1'b1, 6'b000000, "repulse_end"};
    vecs[12] = '{8, 1'b1, 6'b000000, "requalify"};
    vecs[13] = '{1, 1'b1, 6'b010000, "rerun"};

    bus.dcm_locked = 1'b0;
    @(negedge clk);
    apply_reset();

    // Bring-up, qualification, and lock loss from RUN
    for (int i = 0; i < 14; i++) begin
      steps(vecs[i].n, vecs[i].lk);
      check(vecs[i].name, outs(), vecs[i].exp);
    end

    // Lock glitch during STABLE restarts qualification without a DCM reset
    apply_reset();
    steps(8, 1'b1);
    steps(3, 1'b0);
    steps(10, 1'b1);
    check("glitch_not_ready", outs(), 6'b000000);
    step(1'b1);
    check("glitch_requalified", outs(), 6'b010000);

    // No lock at all: three attempts then sticky fault
    apply_reset();
    steps(71, 1'b0);
    check("last_wait", outs(), 6'b000010);
    step(1'b0);
    check("fault_set", outs(), 6'b000110);
    steps(30, 1'b1);
    check("fault_sticky", outs(), 6'b000110);

    // Async reset in the middle of WAIT_LOCK (cnt==12)
    apply_reset();
    steps(4 + 12, 1'b0);
    #3;
    apply_reset();
    steps(3, 1'b0);
    check("post_rst_pulse", outs(), 6'b100000);
    step(1'b0);
    check("post_rst_pulse_end", outs(), 6'b000000);
    steps(19, 1'b0);
    check("fresh_window", outs(), 6'b000000);
    step(1'b0);
    check("fresh_timeout", outs(), 6'b100001);

    // Lock seen on the same cycle as the timeout: lock wins
    apply_reset();
    steps(21, 1'b0);
    steps(3, 1'b1);
    check("lock_beats_timeout", outs(), 6'b000000);
    steps(7, 1'b1);
    check("edge_lock_qual", outs(), 6'b000000);
    step(1'b1);
    check("edge_lock_run", outs(), 6'b010000);

    // Randomized lock patterns against the reference model
    apply_reset();
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 19) == 0) apply_reset();
      steps(int'($urandom_range(1, 40)), ($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
